// File: rtl/mcycle_unit_pkg.sv
// rtl/mcycle_unit_pkg.sv - op codes, state codes and op decode helpers for mcycle_unit
package mcycle_unit_pkg;

  typedef enum logic [1:0] {
    MC_SMUL = 2'b00,
    MC_UMUL = 2'b01,
    MC_SDIV = 2'b10,
    MC_UDIV = 2'b11
  } mc_op_e;

  typedef enum logic {
    MC_IDLE    = 1'b0,
    MC_COMPUTE = 1'b1
  } mc_state_e;

  function automatic logic mc_is_div(input mc_op_e op);
    return (op == MC_SDIV) || (op == MC_UDIV);
  endfunction

  function automatic logic mc_is_signed(input mc_op_e op);
    return (op == MC_SMUL) || (op == MC_SDIV);
  endfunction

endpackage

// File: rtl/mcycle_unit.sv
// rtl/mcycle_unit.sv - iterative shift-add multiply / restoring divide, one bit per clock
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  mc_state_e          state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  mc_op_e             op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   result1_q, result1_d;
  logic [WIDTH-1:0]   result2_q, result2_d;

  mc_op_e             op_in;
  logic               signed_in;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_div;
  logic [2*WIDTH-1:0] prod;
  logic               last;
  logic               busy;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
    dividend_d = dividend_q;
    acc_d      = acc_q;
    sr_d       = sr_q;
    result1_d  = result1_q;
    result2_d  = result2_q;
    busy       = 1'b0;

    op_in     = mc_op_e'(MCycleOp);
    signed_in = mc_is_signed(op_in);
    mag1      = neg_w(Operand1, signed_in & Operand1[WIDTH-1]);
    mag2      = neg_w(Operand2, signed_in & Operand2[WIDTH-1]);
    last      = (count_q == CW'(WIDTH - 1));

    // Multiply: acc = {partial product, remaining multiplier bits}, multiplicand in sr.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? sr_q : '0)};
    acc_mul = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, divisor in sr; quotient bits enter at the bottom.
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, sr_q};
    acc_div  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod = neg_2w(acc_mul, neg_res_q);

    case (state_q)
      MC_IDLE: begin
        busy = Start;
        if (Start) begin
          op_d       = op_in;
          neg_res_d  = signed_in & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
          neg_rem_d  = signed_in & mc_is_div(op_in) & Operand1[WIDTH-1];
          div0_d     = (Operand2 == '0);
          dividend_d = Operand1;
          acc_d      = mc_is_div(op_in) ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
          sr_d       = mc_is_div(op_in) ? mag2 : mag1;
          count_d    = '0;
          state_d    = MC_COMPUTE;
        end
      end
      MC_COMPUTE: begin
        busy    = 1'b1;
        acc_d   = mc_is_div(op_q) ? acc_div : acc_mul;
        count_d = count_q + 1'b1;
        if (last) begin
          state_d = MC_IDLE;
          if (!mc_is_div(op_q)) begin
            result1_d = prod[WIDTH-1:0];
            result2_d = prod[2*WIDTH-1:WIDTH];
          end else if (div0_q) begin
            result1_d = '1;
            result2_d = dividend_q;
          end else begin
            result1_d = neg_w(acc_div[WIDTH-1:0], neg_res_q);
            result2_d = neg_w(acc_div[2*WIDTH-1:WIDTH], neg_rem_q);
          end
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= MC_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q       <= MC_SMUL;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      dividend_q <= '0;
      acc_q      <= '0;
      sr_q       <= '0;
      result1_q  <= '0;
      result2_q  <= '0;
    end else begin
      op_q       <= op_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
      dividend_q <= dividend_d;
      acc_q      <= acc_d;
      sr_q       <= sr_d;
      result1_q  <= result1_d;
      result2_q  <= result2_d;
    end
  end

  assign Result1 = result1_q;
  assign Result2 = result2_q;
  assign Busy    = busy;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb/tb_mcycle_unit.sv - randomized self-checking bench for mcycle_unit against an arithmetic model
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] prev_res = '0;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Returns {Result2, Result1} computed directly from the arithmetic definition.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    int ia, ib, q, r;
    logic [63:0] up;
    case (op)
      2'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return p;
      end
      2'd1: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ia = a;
        ib = b;
        q  = ia / ib;
        r  = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 15));
      1: return 32'h8000_0000;
      2: return -32'($urandom_range(1, 15));
      3: return 32'($urandom_range(0, 1)) ? 32'h0 : 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int pulse_at);
    logic [63:0] exp;
    int cycles;
    exp = model(op, a, b);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    cycles = 0;
    #1;
    while (Busy && cycles < 200) begin
      cycles++;
      @(negedge CLK);
      Start    = (cycles == pulse_at);
      Operand1 = $urandom;
      Operand2 = $urandom;
      MCycleOp = 2'($urandom);
      #1;
      if (cycles == 5) chk({tag, "_hold"}, {Result2, Result1}, prev_res);
    end
    Start = 1'b0;
    chk({tag, "_busy"}, 64'(cycles), 64'd33);
    chk({tag, "_res"}, {Result2, Result1}, exp);
    prev_res = exp;
  endtask

  task automatic do_b2b(input logic [1:0] op_a, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [1:0] op_b, input logic [31:0] b1, input logic [31:0] b2);
    logic [63:0] exp_a, exp_b;
    int cycles;
    exp_a = model(op_a, a1, a2);
    exp_b = model(op_b, b1, b2);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op_a; Operand1 = a1; Operand2 = a2;
    cycles = 0;
    #1;
    while (Busy && cycles < 300) begin
      cycles++;
      @(negedge CLK);
      if (cycles == 33) begin
        chk("b2b_first_res", {Result2, Result1}, exp_a);
        MCycleOp = op_b; Operand1 = b1; Operand2 = b2;
      end else begin
        if (cycles > 33) Start = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
      end
      #1;
    end
    Start = 1'b0;
    chk("b2b_busy", 64'(cycles), 64'd66);
    chk("b2b_second_res", {Result2, Result1}, exp_b);
    prev_res = exp_b;
  endtask

  initial begin
    int cycles;
    logic [1:0] op;
    Reset_n = 1'b0; Start = 1'b0; MCycleOp = 2'd0; Operand1 = '0; Operand2 = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_res", {Result2, Result1}, 64'd0);
    Reset_n = 1'b1;

    do_op("umul_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("umul_max_lit", {Result2, Result1}, 64'hFFFF_FFFE_0000_0001);
    do_op("smul_m3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, -1);
    chk("smul_m3x7_lit", {Result2, Result1}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("umul_m3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, -1);
    chk("umul_m3x7_lit", {Result2, Result1}, 64'h0000_0006_FFFF_FFEB);
    do_op("sdiv_m7d2", 2'd2, 32'hFFFF_FFF9, 32'd2, -1);
    chk("sdiv_m7d2_lit", {Result2, Result1}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("sdiv_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("sdiv_ovf_lit", {Result2, Result1}, 64'h0000_0000_8000_0000);
    do_op("udiv_by0", 2'd3, 32'd100, 32'd0, -1);
    chk("udiv_by0_lit", {Result2, Result1}, 64'h0000_0064_FFFF_FFFF);
    do_op("sdiv_by0", 2'd2, 32'hFFFF_FFFB, 32'd0, -1);
    chk("sdiv_by0_lit", {Result2, Result1}, 64'hFFFF_FFFB_FFFF_FFFF);
    do_op("sdiv_7dm2", 2'd2, 32'd7, 32'hFFFF_FFFE, -1);

    do_op("pulse_mid", 2'd0, 32'h1234_5678, 32'hFEDC_BA98, 6);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      do_op($sformatf("rnd%0d", i), op, pick(), pick(), -1);
    end

    do_b2b(2'd3, 32'hDEAD_BEEF, 32'd1234, 2'd0, 32'hFFFF_8000, 32'h0001_0003);

    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'd1; Operand1 = $urandom; Operand2 = $urandom;
    cycles = 0;
    while (cycles < 11) begin
      cycles++;
      @(negedge CLK);
      Start = 1'b0;
    end
    Reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_res", {Result2, Result1}, 64'd0);
    @(negedge CLK);
    Reset_n = 1'b1;
    prev_res = '0;
    do_op("post_rst_6x7", 2'd1, 32'd6, 32'd7, -1);
    chk("post_rst_6x7_lit", {Result2, Result1}, 64'd42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
